// File: rtl/sap_ctrl_pkg.sv
// Shared control-bit map, opcode encodings, flag indices and microword layout for the SAP sequencer.
package sap_ctrl_pkg;

    // Control word bits (bit 15 is HALT)
    localparam logic [15:0] HALT = 16'h8000;
    localparam logic [15:0] MI   = 16'h4000;
    localparam logic [15:0] RI   = 16'h2000;
    localparam logic [15:0] RO   = 16'h1000;
    localparam logic [15:0] IO   = 16'h0800;
    localparam logic [15:0] II   = 16'h0400;
    localparam logic [15:0] AI   = 16'h0200;
    localparam logic [15:0] AO   = 16'h0100;
    localparam logic [15:0] SMO  = 16'h0080;
    localparam logic [15:0] SU   = 16'h0040;
    localparam logic [15:0] BI   = 16'h0020;
    localparam logic [15:0] OI   = 16'h0010;
    localparam logic [15:0] CE   = 16'h0008;
    localparam logic [15:0] CO   = 16'h0004;
    localparam logic [15:0] JE   = 16'h0002;
    localparam logic [15:0] FI   = 16'h0001;

    localparam int OP_NOP = 0;
    localparam int OP_LDA = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_STA = 4;
    localparam int OP_LDI = 5;
    localparam int OP_JMP = 6;
    localparam int OP_JC  = 7;
    localparam int OP_JZ  = 8;
    localparam int OP_OUT = 14;
    localparam int OP_HLT = 15;

    localparam int FLAG_C = 7;
    localparam int FLAG_Z = 6;

    // Microword layout, LSB first: ctrl, cond_idx, cond_en, end
    localparam int UW_CTRL_LSB = 0;

    function automatic int cidx_width(int flag_w);
        return (flag_w > 1) ? $clog2(flag_w) : 1;
    endfunction

    function automatic int uw_cidx_lsb(int ctrl_w);
        return ctrl_w;
    endfunction

    function automatic int uw_cond_bit(int ctrl_w, int cidx_w);
        return ctrl_w + cidx_w;
    endfunction

    function automatic int uw_end_bit(int ctrl_w, int cidx_w);
        return ctrl_w + cidx_w + 1;
    endfunction

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/sap_ucode_rom.sv
// Combinational microcode table: (opcode, step) -> {end, cond_en, cond_idx, ctrl}.
module sap_ucode_rom
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3,
    parameter int FLAG_W   = 8,
    parameter int CTRL_W   = 16,
    localparam int CIDX_W  = cidx_width(FLAG_W),
    localparam int UW_W    = CTRL_W + CIDX_W + 2
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [STEP_W-1:0]   step,
    output logic [UW_W-1:0]     uword
);

    logic              w_end;
    logic              w_cond;
    logic [CIDX_W-1:0] w_cidx;
    logic [CTRL_W-1:0] w_ctrl;
    int                s;

    // Past the end of any program the word is a terminating no-op
    always_comb begin
        w_end  = 1'b1;
        w_cond = 1'b0;
        w_cidx = '0;
        w_ctrl = '0;
        s      = int'(step);
        if (s == 0) begin
            w_end  = 1'b0;
            w_ctrl = CTRL_W'(MI | CO | CE);
        end else if (s == 1) begin
            w_end  = 1'b0;
            w_ctrl = CTRL_W'(RO | II);
        end else begin
            case (int'(opcode))
                OP_LDA: case (s)
                    2: begin w_end = 1'b0; w_ctrl = CTRL_W'(IO | MI); end
                    3: w_ctrl = CTRL_W'(RO | AI);
                    default: ;
                endcase
                OP_ADD: case (s)
                    2: begin w_end = 1'b0; w_ctrl = CTRL_W'(IO | MI); end
                    3: begin w_end = 1'b0; w_ctrl = CTRL_W'(RO | BI); end
                    4: w_ctrl = CTRL_W'(SMO | AI | FI);
                    default: ;
                endcase
                OP_SUB: case (s)
                    2: begin w_end = 1'b0; w_ctrl = CTRL_W'(IO | MI); end
                    3: begin w_end = 1'b0; w_ctrl = CTRL_W'(RO | BI); end
                    4: w_ctrl = CTRL_W'(SMO | SU | AI | FI);
                    default: ;
                endcase
                OP_STA: case (s)
                    2: begin w_end = 1'b0; w_ctrl = CTRL_W'(IO | MI); end
                    3: w_ctrl = CTRL_W'(AO | RI);
                    default: ;
                endcase
                OP_LDI: if (s == 2) w_ctrl = CTRL_W'(IO | AI);
                OP_JMP: if (s == 2) w_ctrl = CTRL_W'(IO | JE);
                OP_JC: if (s == 2) begin
                    w_ctrl = CTRL_W'(IO | JE);
                    w_cond = 1'b1;
                    w_cidx = CIDX_W'(FLAG_C);
                end
                OP_JZ: if (s == 2) begin
                    w_ctrl = CTRL_W'(IO | JE);
                    w_cond = 1'b1;
                    w_cidx = CIDX_W'(FLAG_Z);
                end
                OP_OUT: if (s == 2) w_ctrl = CTRL_W'(AO | OI);
                OP_HLT: if (s == 2) w_ctrl = CTRL_W'(HALT);
                default: ;
            endcase
        end
    end

    assign uword = {w_end, w_cond, w_cidx, w_ctrl};

endmodule

// File: rtl/sap_microseq.sv
// Microcode sequencer: step counter, condition gating, halt latch and registered control word.
// Optional single-step gating is enabled with `define SAP_SINGLE_STEP_EN.
module sap_microseq
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3,
    parameter int FLAG_W   = 8,
    parameter int CTRL_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FLAG_W-1:0]   flags,
`ifdef SAP_SINGLE_STEP_EN
    input  logic                step_mode,
    input  logic                step_go,
`endif
    output logic [CTRL_W-1:0]   ctrl,
    output logic [STEP_W-1:0]   step,
    output logic                halted
);

    localparam int CIDX_W = cidx_width(FLAG_W);
    localparam int UW_W   = CTRL_W + CIDX_W + 2;
    localparam int CIDX_L = uw_cidx_lsb(CTRL_W);
    localparam int COND_B = uw_cond_bit(CTRL_W, CIDX_W);
    localparam int END_B  = uw_end_bit(CTRL_W, CIDX_W);
    localparam logic [CTRL_W-1:0] HALT_MASK = CTRL_W'(HALT);

    seq_state_t        state, state_next;
    logic [STEP_W-1:0] step_next;
    logic [CTRL_W-1:0] ctrl_next;
    logic [UW_W-1:0]   uword;
    logic [CTRL_W-1:0] gated_ctrl;
    logic              word_end;
    logic              advance;

    sap_ucode_rom #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W),
        .FLAG_W   (FLAG_W),
        .CTRL_W   (CTRL_W)
    ) u_rom (
        .opcode (opcode),
        .step   (step),
        .uword  (uword)
    );

    // The last possible step always terminates, whatever the table says
    assign word_end   = uword[END_B] | (step == {STEP_W{1'b1}});
    assign gated_ctrl = (uword[COND_B] && !flags[uword[CIDX_L +: CIDX_W]])
                        ? '0 : uword[UW_CTRL_LSB +: CTRL_W];

`ifdef SAP_SINGLE_STEP_EN
    assign advance = !step_mode || step_go;
`else
    assign advance = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            step  <= '0;
            ctrl  <= '0;
        end else begin
            state <= state_next;
            step  <= step_next;
            ctrl  <= ctrl_next;
        end
    end

    // Halt is entered on the same edge that registers the HALT bit into ctrl
    always_comb begin
        state_next = state;
        step_next  = step;
        ctrl_next  = '0;
        case (state)
            ST_RUN: begin
                if (advance) begin
                    ctrl_next = gated_ctrl;
                    step_next = word_end ? '0 : step + STEP_W'(1);
                    if (|(gated_ctrl & HALT_MASK))
                        state_next = ST_HALT;
                end
            end
            ST_HALT: ctrl_next = HALT_MASK;
            default: state_next = ST_RUN;
        endcase
    end

    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_sap_microseq.sv
// Randomized self-checking bench for sap_microseq against an instruction-program reference model.
module tb_sap_microseq;
    import sap_ctrl_pkg::*;

    typedef logic [15:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic [7:0]  flags;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;
`ifdef SAP_SINGLE_STEP_EN
    logic        step_mode;
    logic        step_go;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sap_microseq dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .flags     (flags),
`ifdef SAP_SINGLE_STEP_EN
        .step_mode (step_mode),
        .step_go   (step_go),
`endif
        .ctrl      (ctrl),
        .step      (step),
        .halted    (halted)
    );

    // Reference: each instruction is the fetch pair followed by its program
    function automatic word_q_t program_of(int op, logic [7:0] f);
        word_q_t p;
        p.push_back(MI | CO | CE);
        p.push_back(RO | II);
        case (op)
            OP_LDA: begin p.push_back(IO | MI); p.push_back(RO | AI); end
            OP_ADD: begin p.push_back(IO | MI); p.push_back(RO | BI); p.push_back(SMO | AI | FI); end
            OP_SUB: begin p.push_back(IO | MI); p.push_back(RO | BI); p.push_back(SMO | SU | AI | FI); end
            OP_STA: begin p.push_back(IO | MI); p.push_back(AO | RI); end
            OP_LDI: p.push_back(IO | AI);
            OP_JMP: p.push_back(IO | JE);
            OP_JC:  p.push_back(f[7] ? (IO | JE) : 16'h0000);
            OP_JZ:  p.push_back(f[6] ? (IO | JE) : 16'h0000);
            OP_OUT: p.push_back(AO | OI);
            OP_HLT: p.push_back(16'h8000);
            default: p.push_back(16'h0000);
        endcase
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        checks++;
        if (ctrl !== 16'h0000 || step !== 3'd0 || halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: ctrl=%h step=%0d halted=%b, expected ctrl=0000 step=0 halted=0",
                     tag, ctrl, step, halted);
        end
        reset = 1'b0;
    endtask

    // Runs one whole instruction from step 0, checking every micro-step
    task automatic run_instruction(input int op, input logic [7:0] fix_flags,
                                   input bit rand_flags, input string tag);
        word_q_t p;
        int      len;
        logic [2:0] exp_step;
        opcode = 4'(op);
        len    = program_of(op, 8'h00).size();
        for (int i = 0; i < len; i++) begin
            flags = rand_flags ? 8'($urandom) : fix_flags;
            p = program_of(op, flags);
            tick();
            exp_step = (i == len - 1) ? 3'd0 : 3'(i + 1);
            checks++;
            if (ctrl !== p[i] || step !== exp_step) begin
                errors++;
                $display("[TB] FAIL %s op=%0d word %0d: ctrl=%h step=%0d, expected ctrl=%h step=%0d",
                         tag, op, i, ctrl, step, p[i], exp_step);
            end
            checks++;
            if (halted !== (op == OP_HLT && i == len - 1)) begin
                errors++;
                $display("[TB] FAIL %s op=%0d word %0d halted: got %b expected %b",
                         tag, op, i, halted, (op == OP_HLT && i == len - 1));
            end
        end
    endtask

    task automatic test_reset();
        do_reset("reset_state");
    endtask

    task automatic test_lda();
        run_instruction(OP_LDA, 8'h00, 1'b0, "lda");
    endtask

    task automatic test_sub();
        run_instruction(OP_SUB, 8'h00, 1'b0, "sub");
        run_instruction(OP_NOP, 8'h00, 1'b0, "sub_then_fetch");
    endtask

    task automatic test_cond_jump();
        run_instruction(OP_JC, 8'h00, 1'b0, "jc_clear");
        run_instruction(OP_JC, 8'h80, 1'b0, "jc_set");
        run_instruction(OP_JZ, 8'hbf, 1'b0, "jz_clear");
        run_instruction(OP_JZ, 8'h40, 1'b0, "jz_set");
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 14));
            run_instruction(op, 8'h00, 1'b1, "random");
        end
    endtask

    task automatic test_reset_mid_add();
        opcode = 4'(OP_ADD);
        flags  = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (step !== 3'd3) begin
            errors++;
            $display("[TB] FAIL mid_add_step: step=%0d expected 3", step);
        end
        do_reset("mid_add_reset");
        tick();
        checks++;
        if (ctrl !== (MI | CO | CE) || step !== 3'd1) begin
            errors++;
            $display("[TB] FAIL mid_add_refetch: ctrl=%h step=%0d expected ctrl=%h step=1",
                     ctrl, step, MI | CO | CE);
        end
        do_reset("mid_add_cleanup");
    endtask

    task automatic test_halt();
        run_instruction(OP_HLT, 8'h00, 1'b0, "hlt");
        for (int i = 0; i < 20; i++) begin
            opcode = 4'($urandom);
            flags  = 8'($urandom);
            tick();
            checks++;
            if (ctrl !== 16'h8000 || halted !== 1'b1 || step !== 3'd0) begin
                errors++;
                $display("[TB] FAIL halt_hold cycle %0d: ctrl=%h halted=%b step=%0d expected 8000 1 0",
                         i, ctrl, halted, step);
            end
        end
        do_reset("halt_reset");
    endtask

`ifdef SAP_SINGLE_STEP_EN
    task automatic test_single_step();
        word_q_t p;
        step_mode = 1'b1;
        step_go   = 1'b0;
        opcode    = 4'(OP_LDA);
        flags     = 8'h00;
        p = program_of(OP_LDA, flags);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (ctrl !== 16'h0000 || step !== 3'd0) begin
                errors++;
                $display("[TB] FAIL ss_idle cycle %0d: ctrl=%h step=%0d expected 0000 0", i, ctrl, step);
            end
        end
        for (int i = 0; i < p.size(); i++) begin
            step_go = 1'b1;
            tick();
            step_go = 1'b0;
            checks++;
            if (ctrl !== p[i] || step !== ((i == p.size() - 1) ? 3'd0 : 3'(i + 1))) begin
                errors++;
                $display("[TB] FAIL ss_step %0d: ctrl=%h step=%0d expected ctrl=%h", i, ctrl, step, p[i]);
            end
            for (int k = 0; k < 2; k++) begin
                tick();
                checks++;
                if (ctrl !== 16'h0000 || step !== ((i == p.size() - 1) ? 3'd0 : 3'(i + 1))) begin
                    errors++;
                    $display("[TB] FAIL ss_hold %0d: ctrl=%h step=%0d expected ctrl=0000", i, ctrl, step);
                end
            end
        end
        step_mode = 1'b0;
    endtask
`endif

    initial begin
        reset  = 1'b1;
        opcode = 4'h0;
        flags  = 8'h00;
`ifdef SAP_SINGLE_STEP_EN
        step_mode = 1'b0;
        step_go   = 1'b0;
`endif
        $display("[TB] sap_microseq bench start");
        test_reset();
        test_lda();
        test_sub();
        test_cond_jump();
        test_random();
        test_reset_mid_add();
        test_halt();
`ifdef SAP_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
